// File: rtl/fetch_pc_gen_pkg.sv
// Shared definitions for the fetch PC generator: default widths, the
// fetch-group size helper and the two-state fetch FSM encoding.
package fetch_pc_gen_pkg;

  localparam int FPC_PC_WIDTH    = 32;
  localparam int FPC_ISSUE_WIDTH = 2;
  localparam int FPC_INSTR_BYTES = 4;

  typedef enum logic {
    FPC_IDLE = 1'b0,
    FPC_RUN  = 1'b1
  } fpc_state_e;

  // Bytes covered by one fetch group.
  function automatic int fpc_group_bytes(input int issue_width, input int instr_bytes);
    return issue_width * instr_bytes;
  endfunction

  // Width needed to name a lane inside a group (at least one bit).
  function automatic int fpc_off_width(input int issue_width);
    return (issue_width > 1) ? $clog2(issue_width) : 1;
  endfunction

endpackage

// File: rtl/fpc_redirect_arb.sv
// Priority select of the exception and per-lane redirects. The exception
// wins, otherwise the lowest-index requesting lane. Produces the
// instruction-aligned target, a misalignment flag and the lane offset of
// the target inside its fetch group.
module fpc_redirect_arb
  import fetch_pc_gen_pkg::*;
#(
  parameter int PC_WIDTH    = FPC_PC_WIDTH,
  parameter int ISSUE_WIDTH = FPC_ISSUE_WIDTH,
  parameter int INSTR_BYTES = FPC_INSTR_BYTES,
  parameter int OFF_W       = fpc_off_width(ISSUE_WIDTH)
) (
  input  logic [ISSUE_WIDTH-1:0]          redirect_i,
  input  logic [ISSUE_WIDTH*PC_WIDTH-1:0] redirect_pc_i,
  input  logic                            exc_i,
  input  logic [PC_WIDTH-1:0]             exc_pc_i,
  output logic                            take_o,
  output logic [PC_WIDTH-1:0]             target_o,
  output logic                            misalign_o,
  output logic [OFF_W-1:0]                lane_off_o
);

  localparam int GROUP_BYTES = fpc_group_bytes(ISSUE_WIDTH, INSTR_BYTES);
  localparam int IB_SHIFT    = $clog2(INSTR_BYTES);
  localparam logic [PC_WIDTH-1:0] IB_MASK = PC_WIDTH'(INSTR_BYTES - 1);

  logic [PC_WIDTH-1:0] raw_pc;
  logic [PC_WIDTH-1:0] group_off;

  // Pick the winning request; scanning from the top lets lower lanes override.
  always_comb begin
    take_o = 1'b0;
    raw_pc = '0;
    for (int i = ISSUE_WIDTH - 1; i >= 0; i--) begin
      if (redirect_i[i]) begin
        take_o = 1'b1;
        raw_pc = redirect_pc_i[i*PC_WIDTH +: PC_WIDTH];
      end
    end
    if (exc_i) begin
      take_o = 1'b1;
      raw_pc = exc_pc_i;
    end
    misalign_o = |(raw_pc & IB_MASK);
    target_o   = raw_pc & ~IB_MASK;
    group_off  = target_o % PC_WIDTH'(GROUP_BYTES);
    lane_off_o = OFF_W'(group_off >> IB_SHIFT);
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// N-wide fetch PC generator: presents ISSUE_WIDTH consecutive lane PCs per
// group over a valid/ready handshake, takes prioritised redirects, optionally
// aligns to group boundaries with lane masking, and tags groups with an epoch.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int                  PC_WIDTH     = FPC_PC_WIDTH,
  parameter int                  ISSUE_WIDTH  = FPC_ISSUE_WIDTH,
  parameter int                  INSTR_BYTES  = FPC_INSTR_BYTES,
  parameter int                  ALIGN_GROUP  = 1,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  EPOCH_WIDTH  = 3
) (
  input  logic                            fpc_i_clk,
  input  logic                            fpc_i_rst,
  input  logic                            fpc_i_ce,
  input  logic                            fpc_i_ready,
  input  logic [ISSUE_WIDTH-1:0]          fpc_i_redirect,
  input  logic [ISSUE_WIDTH*PC_WIDTH-1:0] fpc_i_redirect_pc,
  input  logic                            fpc_i_exc,
  input  logic [PC_WIDTH-1:0]             fpc_i_exc_pc,
  output logic                            fpc_o_valid,
  output logic [ISSUE_WIDTH*PC_WIDTH-1:0] fpc_o_pc,
  output logic [ISSUE_WIDTH-1:0]          fpc_o_lane_valid,
  output logic [EPOCH_WIDTH-1:0]          fpc_o_epoch,
  output logic                            fpc_o_misalign
);

  localparam int GROUP_BYTES = fpc_group_bytes(ISSUE_WIDTH, INSTR_BYTES);
  localparam int OFF_W       = fpc_off_width(ISSUE_WIDTH);
  localparam int IB_SHIFT    = $clog2(INSTR_BYTES);

  fpc_state_e                    state_q, state_d;
  logic [PC_WIDTH-1:0]           base_q, base_d;
  logic [ISSUE_WIDTH*PC_WIDTH-1:0] pc_q, pc_d;
  logic [ISSUE_WIDTH-1:0]        lane_valid_q, lane_valid_d;
  logic [EPOCH_WIDTH-1:0]        epoch_q, epoch_d;
  logic                          misalign_q, misalign_d;

  logic                          arb_take;
  logic [PC_WIDTH-1:0]           arb_target;
  logic                          arb_misalign;
  logic [OFF_W-1:0]              arb_lane_off;
  logic [PC_WIDTH-1:0]           aligned_base;

  // Lane i PC is base + i*INSTR_BYTES, wrapping silently.
  function automatic logic [ISSUE_WIDTH*PC_WIDTH-1:0] lane_pcs(input logic [PC_WIDTH-1:0] b);
    logic [ISSUE_WIDTH*PC_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      r[i*PC_WIDTH +: PC_WIDTH] = b + PC_WIDTH'(i * INSTR_BYTES);
    end
    return r;
  endfunction

  fpc_redirect_arb #(
    .PC_WIDTH    (PC_WIDTH),
    .ISSUE_WIDTH (ISSUE_WIDTH),
    .INSTR_BYTES (INSTR_BYTES),
    .OFF_W       (OFF_W)
  ) u_arb (
    .redirect_i    (fpc_i_redirect),
    .redirect_pc_i (fpc_i_redirect_pc),
    .exc_i         (fpc_i_exc),
    .exc_pc_i      (fpc_i_exc_pc),
    .take_o        (arb_take),
    .target_o      (arb_target),
    .misalign_o    (arb_misalign),
    .lane_off_o    (arb_lane_off)
  );

  assign aligned_base = arb_target - (PC_WIDTH'(arb_lane_off) << IB_SHIFT);

  // Next state: redirects beat the handshake; the FSM only follows fetch enable.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    lane_valid_d = lane_valid_q;
    epoch_d      = epoch_q;
    misalign_d   = 1'b0;
    if (arb_take) begin
      epoch_d    = epoch_q + EPOCH_WIDTH'(1);
      misalign_d = arb_misalign;
      if (ALIGN_GROUP != 0) begin
        base_d = aligned_base;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
          lane_valid_d[i] = (32'(i) >= 32'(arb_lane_off));
        end
      end else begin
        base_d       = arb_target;
        lane_valid_d = '1;
      end
    end else if (state_q == FPC_RUN && fpc_i_ready) begin
      base_d       = base_q + PC_WIDTH'(GROUP_BYTES);
      lane_valid_d = '1;
    end
    case (state_q)
      FPC_IDLE: if (fpc_i_ce)  state_d = FPC_RUN;
      FPC_RUN:  if (!fpc_i_ce) state_d = FPC_IDLE;
      default:  state_d = FPC_IDLE;
    endcase
    pc_d = lane_pcs(base_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge fpc_i_clk) begin
    if (fpc_i_rst) begin
      state_q      <= FPC_IDLE;
      base_q       <= RESET_VECTOR;
      pc_q         <= lane_pcs(RESET_VECTOR);
      lane_valid_q <= '1;
      epoch_q      <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      pc_q         <= pc_d;
      lane_valid_q <= lane_valid_d;
      epoch_q      <= epoch_d;
      misalign_q   <= misalign_d;
    end
  end

  assign fpc_o_valid      = (state_q == FPC_RUN);
  assign fpc_o_pc         = pc_q;
  assign fpc_o_lane_valid = lane_valid_q;
  assign fpc_o_epoch      = epoch_q;
  assign fpc_o_misalign   = misalign_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: a group-aligned instance and an unaligned instance
// with a nonzero reset vector share stimulus; a behavioural model of each is
// compared every cycle, and directed steps pin the expected behaviour.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        rst, ce, ready, exc;
  logic [1:0]  redir;
  logic [63:0] rpc;
  logic [31:0] exc_pc;

  logic        a_valid, b_valid, a_mis, b_mis;
  logic [63:0] a_pc, b_pc;
  logic [1:0]  a_lane, b_lane;
  logic [2:0]  a_epoch, b_epoch;

  int checks = 0;
  int errors = 0;

  // Model state per instance: index 0 = aligned, 1 = unaligned.
  logic [31:0] m_base  [2];
  logic [1:0]  m_mask  [2];
  logic [2:0]  m_epoch [2];
  logic        m_run   [2];
  logic        m_mis   [2];
  logic        model_ready = 1'b0;
  int          align_of [2] = '{1, 0};
  logic [31:0] rv_of    [2] = '{32'h0, 32'h1000};

  logic        mf;
  logic [31:0] mraw, mt, moff;

  always #5 clk = ~clk;

  fetch_pc_gen #(.PC_WIDTH(32), .ISSUE_WIDTH(2), .INSTR_BYTES(4), .ALIGN_GROUP(1),
                 .RESET_VECTOR(32'h0), .EPOCH_WIDTH(3)) dut (
    .fpc_i_clk(clk), .fpc_i_rst(rst), .fpc_i_ce(ce), .fpc_i_ready(ready),
    .fpc_i_redirect(redir), .fpc_i_redirect_pc(rpc), .fpc_i_exc(exc), .fpc_i_exc_pc(exc_pc),
    .fpc_o_valid(a_valid), .fpc_o_pc(a_pc), .fpc_o_lane_valid(a_lane),
    .fpc_o_epoch(a_epoch), .fpc_o_misalign(a_mis));

  fetch_pc_gen #(.PC_WIDTH(32), .ISSUE_WIDTH(2), .INSTR_BYTES(4), .ALIGN_GROUP(0),
                 .RESET_VECTOR(32'h1000), .EPOCH_WIDTH(3)) dut_na (
    .fpc_i_clk(clk), .fpc_i_rst(rst), .fpc_i_ce(ce), .fpc_i_ready(ready),
    .fpc_i_redirect(redir), .fpc_i_redirect_pc(rpc), .fpc_i_exc(exc), .fpc_i_exc_pc(exc_pc),
    .fpc_o_valid(b_valid), .fpc_o_pc(b_pc), .fpc_o_lane_valid(b_lane),
    .fpc_o_epoch(b_epoch), .fpc_o_misalign(b_mis));

  function automatic logic [70:0] pack_a();
    return {a_valid, a_pc, a_lane, a_epoch, a_mis};
  endfunction

  function automatic logic [70:0] pack_b();
    return {b_valid, b_pc, b_lane, b_epoch, b_mis};
  endfunction

  function automatic logic [70:0] exp_of(input int k);
    return {m_run[k], m_base[k] + 32'd4, m_base[k], m_mask[k], m_epoch[k], m_mis[k]};
  endfunction

  // Field order in reports: valid, pc1, pc0, lane_valid, epoch, misalign.
  task automatic check_output(input string name, input logic [70:0] act, input logic [70:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got v=%b pc=%h_%h lane=%b ep=%0d mis=%b, expected v=%b pc=%h_%h lane=%b ep=%0d mis=%b",
               name, act[70], act[69:38], act[37:6], act[5:4], act[3:1], act[0],
               exp[70], exp[69:38], exp[37:6], exp[5:4], exp[3:1], exp[0]);
    end
  endtask

  // Drive one cycle of inputs and return just after the active edge.
  task automatic apply_stimulus(input logic r, input logic c, input logic rdy,
                                input logic [1:0] rd, input logic [31:0] p0, input logic [31:0] p1,
                                input logic e, input logic [31:0] ep);
    rst = r; ce = c; ready = rdy; redir = rd; rpc = {p1, p0}; exc = e; exc_pc = ep;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return $urandom;
    if (sel == 1) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return $urandom & 32'h0000_0FFF;
  endfunction

  // Behavioural reference: redirect choice, alignment and advance from plain arithmetic.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_run[k] = 1'b0; m_base[k] = rv_of[k]; m_mask[k] = 2'b11;
        m_epoch[k] = 3'd0; m_mis[k] = 1'b0;
      end else begin
        mf = 1'b0; mraw = 32'h0;
        if (exc) begin
          mf = 1'b1; mraw = exc_pc;
        end else if (redir[0]) begin
          mf = 1'b1; mraw = rpc[31:0];
        end else if (redir[1]) begin
          mf = 1'b1; mraw = rpc[63:32];
        end
        m_mis[k] = 1'b0;
        if (mf) begin
          mt = mraw - (mraw % 4);
          m_mis[k] = (mraw % 4) != 0;
          if (align_of[k] == 1) begin
            moff = mt % 8;
            m_base[k] = mt - moff;
            m_mask[k] = (moff / 4 == 0) ? 2'b11 : 2'b10;
          end else begin
            m_base[k] = mt;
            m_mask[k] = 2'b11;
          end
          m_epoch[k] = m_epoch[k] + 3'd1;
        end else if (m_run[k] && ready) begin
          m_base[k] = m_base[k] + 32'd8;
          m_mask[k] = 2'b11;
        end
        m_run[k] = ce;
      end
    end
    if (rst) model_ready = 1'b1;
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_ready) begin
      check_output("model_aligned", pack_a(), exp_of(0));
      check_output("model_unaligned", pack_b(), exp_of(1));
    end
  end

  // Directed sequence with literal expectations, then randomized traffic.
  initial begin
    logic [1:0] rd;
    apply_stimulus(1, 0, 1, 2'b00, 0, 0, 0, 0);
    apply_stimulus(1, 0, 1, 2'b00, 0, 0, 0, 0);
    check_output("reset_a", pack_a(), {1'b0, 32'h4, 32'h0, 2'b11, 3'd0, 1'b0});
    check_output("reset_b", pack_b(), {1'b0, 32'h1004, 32'h1000, 2'b11, 3'd0, 1'b0});

    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 0, 0);
    check_output("first_group", pack_a(), {1'b1, 32'h4, 32'h0, 2'b11, 3'd0, 1'b0});
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 0, 0);
    check_output("second_group", pack_a(), {1'b1, 32'hC, 32'h8, 2'b11, 3'd0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 1, 0, 2'b00, 0, 0, 0, 0);
      check_output("stall_hold", pack_a(), {1'b1, 32'hC, 32'h8, 2'b11, 3'd0, 1'b0});
    end
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 0, 0);
    check_output("after_stall", pack_a(), {1'b1, 32'h14, 32'h10, 2'b11, 3'd0, 1'b0});

    apply_stimulus(0, 1, 1, 2'b11, 32'h200, 32'h104, 0, 0);
    check_output("lane0_priority", pack_a(), {1'b1, 32'h204, 32'h200, 2'b11, 3'd1, 1'b0});
    apply_stimulus(0, 1, 1, 2'b10, 0, 32'h104, 0, 0);
    check_output("lane1_masked", pack_a(), {1'b1, 32'h104, 32'h100, 2'b10, 3'd2, 1'b0});
    check_output("lane1_unaligned", pack_b(), {1'b1, 32'h108, 32'h104, 2'b11, 3'd2, 1'b0});
    apply_stimulus(0, 1, 1, 2'b01, 32'h300, 0, 1, 32'h80);
    check_output("exc_priority", pack_a(), {1'b1, 32'h84, 32'h80, 2'b11, 3'd3, 1'b0});
    apply_stimulus(0, 1, 0, 2'b01, 32'h206, 0, 0, 0);
    check_output("misalign_pulse", pack_a(), {1'b1, 32'h204, 32'h200, 2'b10, 3'd4, 1'b1});
    apply_stimulus(0, 1, 0, 2'b00, 0, 0, 0, 0);
    check_output("misalign_clear", pack_a(), {1'b1, 32'h204, 32'h200, 2'b10, 3'd4, 1'b0});

    apply_stimulus(0, 1, 1, 2'b01, 32'hFFFF_FFF8, 0, 0, 0);
    check_output("top_of_space", pack_a(), {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 2'b11, 3'd5, 1'b0});
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 0, 0);
    check_output("wrap_a", pack_a(), {1'b1, 32'h4, 32'h0, 2'b11, 3'd5, 1'b0});
    check_output("wrap_b", pack_b(), {1'b1, 32'h4, 32'h0, 2'b11, 3'd5, 1'b0});

    apply_stimulus(1, 1, 1, 2'b00, 0, 0, 0, 0);
    check_output("midrun_reset_a", pack_a(), {1'b0, 32'h4, 32'h0, 2'b11, 3'd0, 1'b0});
    check_output("midrun_reset_b", pack_b(), {1'b0, 32'h1004, 32'h1000, 2'b11, 3'd0, 1'b0});
    apply_stimulus(0, 0, 1, 2'b10, 0, 32'h400, 0, 0);
    check_output("idle_redirect", pack_a(), {1'b0, 32'h404, 32'h400, 2'b11, 3'd1, 1'b0});
    apply_stimulus(0, 0, 1, 2'b00, 0, 0, 0, 0);
    check_output("idle_hold", pack_a(), {1'b0, 32'h404, 32'h400, 2'b11, 3'd1, 1'b0});
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 0, 0);
    check_output("resume", pack_a(), {1'b1, 32'h404, 32'h400, 2'b11, 3'd1, 1'b0});
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 0, 0);
    check_output("resume_next", pack_a(), {1'b1, 32'h40C, 32'h408, 2'b11, 3'd1, 1'b0});

    for (int n = 0; n < 3000; n++) begin
      rd[0] = ($urandom_range(0, 7) == 0);
      rd[1] = ($urandom_range(0, 7) == 0);
      apply_stimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                     $urandom_range(0, 3) != 0, rd, rand_pc(), rand_pc(),
                     $urandom_range(0, 15) == 0, rand_pc());
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Parametrised N-wide fetch PC generator; successor to the dual-issue program counter.
- Produces ISSUE_WIDTH consecutive lane PCs per fetch group, with a valid/ready handshake toward the I-cache/fetch stage.
- Accepts prioritised redirects from every issue lane plus an exception redirect.
- Optionally aligns groups to a fetch-group boundary with per-lane masking, and tags each group with a redirect epoch so downstream logic can squash stale fetches.

Parameters:
- PC_WIDTH, 32, PC width in bits (from header.vh).
- ISSUE_WIDTH, 2, lanes per fetch group; must be at least 1.
- INSTR_BYTES, 4, bytes per instruction; must be a power of 2.
- ALIGN_GROUP, 1, 1 = align the group base down to ISSUE_WIDTH*INSTR_BYTES and mask the lanes below the target; 0 = the group starts exactly at the target.
- RESET_VECTOR, 0, first fetch address after reset.
- EPOCH_WIDTH, 3, width of the redirect epoch tag.

Ports:
- fpc_i_clk  in  1  clock.
- fpc_i_rst  in  1  synchronous, active-high reset.
- fpc_i_ce  in  1  fetch enable.
- fpc_i_ready  in  1  downstream accepts the current group.
- fpc_i_redirect  in  ISSUE_WIDTH  per-lane redirect request.
- fpc_i_redirect_pc  in  ISSUE_WIDTH*PC_WIDTH  per-lane target; lane i occupies bits [i*PC_WIDTH +: PC_WIDTH].
- fpc_i_exc  in  1  exception redirect.
- fpc_i_exc_pc  in  PC_WIDTH  exception vector.
- fpc_o_valid  out  1  group valid.
- fpc_o_pc  out  ISSUE_WIDTH*PC_WIDTH  lane PCs, packed the same way as fpc_i_redirect_pc.
- fpc_o_lane_valid  out  ISSUE_WIDTH  per-lane valid mask.
- fpc_o_epoch  out  EPOCH_WIDTH  redirect epoch of the current group.
- fpc_o_misalign  out  1  one-cycle pulse: the accepted redirect target was misaligned.

Behaviour:
- Reset (sampled on the fpc_i_clk edge while fpc_i_rst=1):
  - valid=0, epoch=0, misalign=0, lane_valid=all ones.
  - Internal base = RESET_VECTOR; lane i PC = RESET_VECTOR + i*INSTR_BYTES.
  - Reset mid-operation discards any pending redirect and returns to IDLE.
- State machine:
  - IDLE: valid=0; moves to RUN on the edge where ce=1.
  - RUN: valid=1; moves to IDLE on the edge where ce=0. PCs and epoch are retained, not zeroed.
- All outputs are registered. Redirect latency is 1: a redirect sampled at edge t appears on the outputs after edge t.
- Redirect priority, highest first: fpc_i_exc, then the lowest-index asserted fpc_i_redirect lane. All lower-priority requests in that cycle are ignored.
- On an accepted redirect:
  - The target has its low log2(INSTR_BYTES) bits cleared. If any of those bits were nonzero, misalign=1 for one cycle.
  - With ALIGN_GROUP=1: base = target aligned down to GROUP = ISSUE_WIDTH*INSTR_BYTES; lane_valid[i] = 1 iff i >= (target mod GROUP)/INSTR_BYTES.
  - With ALIGN_GROUP=0: base = target; lane_valid = all ones.
  - epoch increments, wrapping modulo 2^EPOCH_WIDTH.
  - A redirect is taken regardless of ready; it flushes the held group.
  - A redirect while ce=0 updates base and epoch and stays in IDLE; fetch resumes from that target when ce rises.
- Handshake:
  - valid & !ready & no redirect: every output holds stable.
  - valid & ready & no redirect: base advances by GROUP, lane_valid = all ones.
- Arithmetic: lane PC = base + i*INSTR_BYTES, modulo 2^PC_WIDTH, so wrap-around is silent.
- misalign is 0 in every cycle without a misaligned accepted redirect.

Decomposition:
- Shared header.vh holds: PC_WIDTH, the default ISSUE_WIDTH, GROUP_BYTES = ISSUE_WIDTH*INSTR_BYTES, and the FPC_IDLE/FPC_RUN state encodings.
- One sub-module, fpc_redirect_arb: combinational priority select of the exception and lane redirects, producing the chosen target, the misalign flag and the lane offset.

Test Plan (ISSUE_WIDTH=2, INSTR_BYTES=4, ALIGN_GROUP=1, RESET_VECTOR=0 unless stated):
- Release reset, ce=1, ready=1 -> groups {0x0,0x4}, {0x8,0xC}, {0x10,0x14}; valid=1 from the first edge after reset; lane_valid=11.
- ready=0 for 3 cycles while group {0x8,0xC} is presented -> outputs stable for all 3 cycles; group {0x10,0x14} follows on the cycle after ready=1.
- Simultaneous redirect lane0=0x200 and lane1=0x104 -> {0x200,0x204}, lane_valid=11, epoch 0->1. Then lane1 alone to 0x104 -> base 0x100, lane_valid=10, epoch=2.
- fpc_i_exc with exc_pc=0x80 together with redirect lane0=0x300 -> {0x80,0x84}, epoch +1. Then lane0 redirect to 0x206 -> base 0x200, lane_valid=10, misalign pulses for exactly one cycle.
- ALIGN_GROUP=0, base 0xFFFFFFF8 accepted -> {0x0,0x4}. Assert rst mid-run -> valid=0 and PC=RESET_VECTOR on the next edge; after ce toggles 0->1, fetch resumes at the latest redirect target.
